// File: rtl/instruction_fetch_if.sv
// Handshake bundle between the fetch unit, the PC register, instruction memory
// and the decode stage. The fetch unit is the master side.
interface instruction_fetch_if;
    logic [31:0] pcIn;
    logic        pcCountEnable;
    logic        flush;
    logic [31:0] memAddress;
    logic        memReadRequest;
    logic        memReady;
    logic [31:0] memDataIn;
    logic [31:0] instrOut;
    logic        instrValid;
    logic        instrReady;
    logic        fetchFault;

    modport master (
        input  pcIn,
        input  flush,
        input  memReady,
        input  memDataIn,
        input  instrReady,
        output pcCountEnable,
        output memAddress,
        output memReadRequest,
        output instrOut,
        output instrValid,
        output fetchFault
    );

    modport slave (
        output pcIn,
        output flush,
        output memReady,
        output memDataIn,
        output instrReady,
        input  pcCountEnable,
        input  memAddress,
        input  memReadRequest,
        input  instrOut,
        input  instrValid,
        input  fetchFault
    );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch FSM: latches the PC, reads one word from memory, hands it to
// the consumer and requests the PC increment; faults on misalignment or timeout.
module instruction_fetch #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    instruction_fetch_if.master  bus
);

    typedef enum logic [1:0] {
        ADDR  = 2'b00,
        FETCH = 2'b01,
        HOLD  = 2'b10,
        FAULT = 2'b11
    } state_t;

    // Counter only has to reach TIMEOUT_CYCLES-1 before the fault is taken.
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TO_LAST =
        CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
    localparam logic TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    state_t             state_r;
    logic [31:0]        mem_address_r;
    logic               mem_read_request_r;
    logic [31:0]        instr_out_r;
    logic               instr_valid_r;
    logic               pc_count_enable_r;
    logic               fetch_fault_r;
    logic [CNT_W-1:0]   timeout_cnt_r;
    logic               drop_r;

    logic               misaligned_s;
    logic               timeout_hit_s;
    logic               drop_now_s;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

    // Decode of the conditions steering the FETCH and ADDR transitions.
    always_comb begin
        misaligned_s  = 1'b0;
        timeout_hit_s = 1'b0;
        drop_now_s    = 1'b0;
        misaligned_s  = is_misaligned(bus.pcIn);
        if (TIMEOUT_EN) begin
            timeout_hit_s = (timeout_cnt_r == TO_LAST);
        end else begin
            timeout_hit_s = 1'b0;
        end
        drop_now_s = drop_r | bus.flush;
    end

    // Fetch FSM with all outputs registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r            <= ADDR;
            mem_address_r      <= 32'h0000_0000;
            mem_read_request_r <= 1'b0;
            instr_out_r        <= 32'h0000_0000;
            instr_valid_r      <= 1'b0;
            pc_count_enable_r  <= 1'b0;
            fetch_fault_r      <= 1'b0;
            timeout_cnt_r      <= '0;
            drop_r             <= 1'b0;
        end else begin
            case (state_r)
                ADDR: begin
                    mem_address_r     <= bus.pcIn;
                    pc_count_enable_r <= 1'b0;
                    instr_valid_r     <= 1'b0;
                    if (bus.flush) begin
                        state_r <= ADDR;
                    end else if (misaligned_s) begin
                        fetch_fault_r <= 1'b1;
                        state_r       <= FAULT;
                    end else begin
                        mem_read_request_r <= 1'b1;
                        timeout_cnt_r      <= '0;
                        drop_r             <= 1'b0;
                        state_r            <= FETCH;
                    end
                end
                FETCH: begin
                    // A response always ends the request; a pending or same-cycle flush discards it.
                    if (bus.memReady) begin
                        mem_read_request_r <= 1'b0;
                        timeout_cnt_r      <= '0;
                        if (drop_now_s) begin
                            drop_r  <= 1'b0;
                            state_r <= ADDR;
                        end else begin
                            instr_out_r       <= bus.memDataIn;
                            instr_valid_r     <= 1'b1;
                            pc_count_enable_r <= 1'b1;
                            state_r           <= HOLD;
                        end
                    end else if (timeout_hit_s) begin
                        mem_read_request_r <= 1'b0;
                        fetch_fault_r      <= 1'b1;
                        drop_r             <= 1'b0;
                        state_r            <= FAULT;
                    end else begin
                        timeout_cnt_r <= timeout_cnt_r + CNT_W'(1);
                        if (bus.flush) begin
                            drop_r <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    // The increment pulse covers only the first HOLD cycle.
                    pc_count_enable_r <= 1'b0;
                    if (bus.flush || bus.instrReady) begin
                        instr_valid_r <= 1'b0;
                        state_r       <= ADDR;
                    end
                end
                FAULT: begin
                    mem_read_request_r <= 1'b0;
                    instr_valid_r      <= 1'b0;
                    pc_count_enable_r  <= 1'b0;
                    if (bus.flush) begin
                        fetch_fault_r <= 1'b0;
                        state_r       <= ADDR;
                    end else begin
                        fetch_fault_r <= 1'b1;
                    end
                end
                default: begin
                    state_r            <= ADDR;
                    mem_read_request_r <= 1'b0;
                    instr_valid_r      <= 1'b0;
                    pc_count_enable_r  <= 1'b0;
                    drop_r             <= 1'b0;
                end
            endcase
        end
    end

    assign bus.memAddress     = mem_address_r;
    assign bus.memReadRequest = mem_read_request_r;
    assign bus.instrOut       = instr_out_r;
    assign bus.instrValid     = instr_valid_r;
    assign bus.pcCountEnable  = pc_count_enable_r;
    assign bus.fetchFault     = fetch_fault_r;

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: a PC model, a memory responder and a
// queue of expected instruction words.
module tb_instruction_fetch;

    logic clk = 1'b0;
    logic reset;

    instruction_fetch_if bus();

    instruction_fetch #(.TIMEOUT_CYCLES(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    int          push_count = 0;
    int          pce_count = 0;
    logic [31:0] pc;
    logic [31:0] sb[$];
    bit          drop_m;
    bit          mem_auto;
    int          mem_lat;
    int          wait_cnt;

    assign bus.pcIn = pc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h0000_0013 + (a << 7);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: score the cycle about to end, then advance PC and memory models.
    task automatic tick();
        logic pce_pre;
        pce_pre = 1'b0;
        if (reset === 1'b1) begin
            if (bus.memReadRequest && bus.memReady) begin
                if (bus.flush || drop_m) begin
                    drop_m = 1'b0;
                end else begin
                    sb.push_back(bus.memDataIn);
                    push_count++;
                end
            end else if (bus.memReadRequest && bus.flush) begin
                drop_m = 1'b1;
            end
            if (bus.instrValid && sb.size() == 0) begin
                check("spurious_valid", 32'(bus.instrValid), 32'd0);
            end else if (bus.instrValid) begin
                check("instr_out", bus.instrOut, sb[0]);
                if (bus.flush || bus.instrReady) void'(sb.pop_front());
            end
            pce_pre = bus.pcCountEnable;
        end
        @(posedge clk);
        #1;
        if (pce_pre) begin
            pc = pc + 32'd4;
            pce_count++;
        end
        if (!bus.memReadRequest) drop_m = 1'b0;
        if (mem_auto) begin
            if (bus.memReadRequest) wait_cnt++;
            else wait_cnt = 0;
            if (bus.memReadRequest && wait_cnt >= mem_lat) begin
                bus.memReady  = 1'b1;
                bus.memDataIn = mem_word(bus.memAddress);
            end else begin
                bus.memReady  = 1'b0;
                bus.memDataIn = 32'hDEAD_BEEF;
            end
        end
    endtask

    task automatic wait_req(input string tag);
        for (int n = 0; n < 20 && bus.memReadRequest !== 1'b1; n++) tick();
        check(tag, 32'(bus.memReadRequest), 32'd1);
    endtask

    task automatic wait_valid(input string tag);
        for (int n = 0; n < 20 && bus.instrValid !== 1'b1; n++) tick();
        check(tag, 32'(bus.instrValid), 32'd1);
    endtask

    initial begin
        int pce0;
        int n;
        reset = 1'b0;
        pc = 32'h0;
        bus.flush = 1'b0;
        bus.memReady = 1'b0;
        bus.memDataIn = 32'h0;
        bus.instrReady = 1'b1;
        mem_auto = 1'b1;
        mem_lat = 1;
        wait_cnt = 0;
        drop_m = 1'b0;
        tick();
        tick();
        check("rst_addr", bus.memAddress, 32'h0);
        check("rst_req", 32'(bus.memReadRequest), 32'd0);
        check("rst_instr", bus.instrOut, 32'h0);
        check("rst_valid", 32'(bus.instrValid), 32'd0);
        check("rst_pce", 32'(bus.pcCountEnable), 32'd0);
        check("rst_fault", 32'(bus.fetchFault), 32'd0);
        reset = 1'b1;

        // Zero-wait memory, consumer always ready: ADDR/FETCH/HOLD cadence.
        wait_req("first_req");
        check("first_addr", bus.memAddress, 32'h0);
        tick();
        check("first_valid", 32'(bus.instrValid), 32'd1);
        check("first_pce", 32'(bus.pcCountEnable), 32'd1);
        check("first_instr", bus.instrOut, 32'h0000_0013);
        tick();
        check("valid_one_cycle", 32'(bus.instrValid), 32'd0);
        check("pce_one_cycle", 32'(bus.pcCountEnable), 32'd0);
        tick();
        check("second_req", 32'(bus.memReadRequest), 32'd1);
        check("second_addr", bus.memAddress, 32'h4);
        for (int i = 0; i < 6; i++) tick();
        check("period3_req", 32'(bus.memReadRequest), 32'd1);
        check("period3_addr", bus.memAddress, 32'hC);

        // Consumer stalls for five cycles in HOLD.
        mem_lat = 2;
        bus.instrReady = 1'b0;
        wait_valid("stall_valid");
        pce0 = pce_count;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_valid_held", 32'(bus.instrValid), 32'd1);
            check("stall_no_req", 32'(bus.memReadRequest), 32'd0);
            check("stall_no_pce", 32'(bus.pcCountEnable), 32'd0);
        end
        check("stall_pce_once", pce_count, pce0 + 1);
        bus.instrReady = 1'b1;
        tick();
        check("stall_accept", 32'(bus.instrValid), 32'd0);

        // Flush during FETCH, response arrives three cycles later.
        mem_auto = 1'b0;
        bus.memReady = 1'b0;
        wait_req("drop_req");
        bus.flush = 1'b1;
        pc = 32'h100;
        tick();
        bus.flush = 1'b0;
        tick();
        tick();
        check("drop_req_held", 32'(bus.memReadRequest), 32'd1);
        bus.memReady = 1'b1;
        bus.memDataIn = 32'h1234_5678;
        tick();
        bus.memReady = 1'b0;
        check("drop_no_valid", 32'(bus.instrValid), 32'd0);
        check("drop_no_pce", 32'(bus.pcCountEnable), 32'd0);
        check("drop_req_off", 32'(bus.memReadRequest), 32'd0);
        mem_auto = 1'b1;
        mem_lat = 1;
        wait_req("after_drop_req");
        check("after_drop_addr", bus.memAddress, 32'h100);

        // Misaligned PC, then recovery through flush.
        bus.instrReady = 1'b0;
        wait_valid("pre_fault_valid");
        tick();
        pc = 32'h6;
        bus.flush = 1'b1;
        tick();
        check("hold_flush_valid", 32'(bus.instrValid), 32'd0);
        bus.flush = 1'b0;
        bus.instrReady = 1'b1;
        tick();
        check("mis_fault", 32'(bus.fetchFault), 32'd1);
        check("mis_addr", bus.memAddress, 32'h6);
        for (int i = 0; i < 3; i++) begin
            check("mis_no_req", 32'(bus.memReadRequest), 32'd0);
            check("mis_fault_sticky", 32'(bus.fetchFault), 32'd1);
            tick();
        end
        pc = 32'h8;
        bus.flush = 1'b1;
        tick();
        check("fault_cleared", 32'(bus.fetchFault), 32'd0);
        bus.flush = 1'b0;
        wait_req("recover_req");
        check("recover_addr", bus.memAddress, 32'h8);

        // Memory never answers: timeout after four FETCH cycles.
        bus.instrReady = 1'b0;
        wait_valid("pre_to_valid");
        tick();
        mem_auto = 1'b0;
        bus.memReady = 1'b0;
        bus.instrReady = 1'b1;
        tick();
        wait_req("to_req");
        check("to_addr", bus.memAddress, 32'hC);
        n = 0;
        while (bus.memReadRequest === 1'b1 && n < 20) begin
            n++;
            tick();
        end
        check("to_cycles", n, 32'd4);
        check("to_fault", 32'(bus.fetchFault), 32'd1);
        pc = 32'h20;
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("to_cleared", 32'(bus.fetchFault), 32'd0);

        // Asynchronous reset in the middle of a fetch.
        wait_req("rst_mid_req");
        tick();
        reset = 1'b0;
        #1;
        check("rst_mid_req_off", 32'(bus.memReadRequest), 32'd0);
        check("rst_mid_addr", bus.memAddress, 32'h0);
        check("rst_mid_valid", 32'(bus.instrValid), 32'd0);
        check("rst_mid_pce", 32'(bus.pcCountEnable), 32'd0);
        check("rst_mid_fault", 32'(bus.fetchFault), 32'd0);
        sb.delete();
        drop_m = 1'b0;
        bus.memReady = 1'b0;
        tick();
        tick();
        pc = 32'h40;
        reset = 1'b1;
        mem_auto = 1'b1;
        wait_req("post_rst_req");
        check("post_rst_addr", bus.memAddress, 32'h40);
        wait_valid("post_rst_valid");
        tick();
        check("post_rst_accept", 32'(bus.instrValid), 32'd0);

        check("sb_empty", 32'(sb.size()), 32'd0);
        check("pce_per_resp", pce_count, push_count);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: FETCH cycles without memReady before fault; 0 disables timeout.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port pcIn  input  32  current program counter value.
REQ-005 SHALL have port pcCountEnable  output  1  one-cycle pulse requesting PC += 4.
REQ-006 SHALL have port flush  input  1  PC is being written (branch/jump); discard in-flight fetch.
REQ-007 SHALL have port memAddress  output  32  fetch address, registered.
REQ-008 SHALL have port memReadRequest  output  1  memory read strobe, held until memReady.
REQ-009 SHALL have port memReady  input  1  memory data valid this cycle.
REQ-010 SHALL have port memDataIn  input  32  instruction word from memory.
REQ-011 SHALL have port instrOut  output  32  fetched instruction, registered.
REQ-012 SHALL have port instrValid  output  1  instrOut valid to consumer.
REQ-013 SHALL have port instrReady  input  1  consumer accepts instrOut when instrValid=1.
REQ-014 SHALL have port fetchFault  output  1  sticky fault: misaligned pcIn or memory timeout.

Function
REQ-015 SHALL implement states ADDR, FETCH, HOLD, FAULT.
REQ-016 ADDR: SHALL latch memAddress <= pcIn; if flush=1 stay ADDR; else if pcIn[1:0]!=0 go FAULT; else go FETCH.
REQ-017 FETCH: SHALL drive memReadRequest=1 with memAddress stable; timeout counter increments each cycle memReady=0.
REQ-018 FETCH with memReady=1 and no pending drop: SHALL capture memDataIn into instrOut, set instrValid=1, pulse pcCountEnable for exactly the next cycle, go HOLD.
REQ-019 flush=1 in FETCH SHALL set a drop flag; request continues until memReady; on memReady data discarded, no instrValid, no pcCountEnable, go ADDR, drop flag cleared.
REQ-020 flush and memReady both 1 in the same FETCH cycle SHALL be treated as a drop (REQ-019).
REQ-021 FETCH with TIMEOUT_CYCLES!=0 and counter reaching TIMEOUT_CYCLES SHALL deassert memReadRequest and go FAULT; counter SHALL clear on every FETCH entry.
REQ-022 HOLD: instrValid=1 and instrOut stable until instrReady=1; on accept SHALL clear instrValid and go ADDR.
REQ-023 flush=1 in HOLD SHALL clear instrValid, go ADDR, issue no further pcCountEnable; flush overrides simultaneous instrReady.
REQ-024 ADDR entered from HOLD SHALL occur no earlier than one cycle after the pcCountEnable pulse, so the latched pcIn is the incremented PC.
REQ-025 FAULT: SHALL hold fetchFault=1, memReadRequest=0, instrValid=0; flush=1 SHALL clear fetchFault and go ADDR.
REQ-026 pcCountEnable SHALL never be asserted more than once per accepted memory response.
REQ-027 Minimum fetch period with zero-wait memory and instrReady=1: 3 cycles (ADDR, FETCH, HOLD).

Reset
REQ-028 reset=0 SHALL asynchronously force state ADDR, memAddress=0, memReadRequest=0, instrOut=0, instrValid=0, pcCountEnable=0, fetchFault=0, timeout counter=0, drop flag=0.
REQ-029 reset asserted mid-FETCH SHALL drop memReadRequest immediately; no instrValid or pcCountEnable after release until a new fetch completes.
REQ-030 first ADDR cycle after reset release SHALL latch pcIn normally.

Verification
REQ-031 pcIn=0x0, memReady one cycle after request, memDataIn=0x00000013, instrReady=1 -> memAddress=0x0, instrOut=0x00000013, instrValid 1 cycle, one pcCountEnable pulse; next memAddress=0x4.
REQ-032 instrReady=0 for 5 cycles in HOLD -> instrValid held, instrOut stable, pcCountEnable pulsed once only, no new memReadRequest.
REQ-033 flush=1 in FETCH, memReady 3 cycles later -> no instrValid, no pcCountEnable, next ADDR latches new pcIn=0x100.
REQ-034 pcIn=0x6 -> fetchFault=1, memReadRequest never asserted; flush=1 with pcIn=0x8 -> fetchFault=0, fetch from 0x8.
REQ-035 TIMEOUT_CYCLES=4, memReady held 0 -> memReadRequest drops after 4 FETCH cycles, fetchFault=1.
REQ-036 reset=0 pulsed mid-FETCH -> all outputs 0 immediately; after release fetch restarts from pcIn.
